// File: rtl/lms_weight_update.sv
// Serial LMS coefficient updater: holds 16 signed 32-bit weights and applies
// one step w_k += ((e*MU) >>> MU_SHIFT) * ref_k per clock, one tap per cycle.
module lms_weight_update #(
  parameter int unsigned MU       = 1,
  parameter int unsigned MU_SHIFT = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         enable_i,
  input  logic         update_req_i,
  input  logic [31:0]  e_i,
  input  logic [223:0] ref_bus_i,
  input  logic         clr_weights_i,
  output logic [511:0] weight_bus_o,
  output logic         busy_o,
  output logic         update_done_o,
  output logic [1:0]   dbg_state_o
);

  // Handshake: update_req_i is a level sampled only in IDLE with enable_i high;
  // there is no ready, the request is simply dropped while busy_o is high.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0]        MU_W  = 16'(MU);
  localparam logic signed [48:0] MAX32 = 49'sd2147483647;
  localparam logic signed [48:0] MIN32 = -49'sd2147483648;

  state_t             state_q;
  logic [3:0]         k_q;
  logic signed [31:0] e_q;
  logic signed [31:0] mu_e_q;
  logic signed [31:0] w_q [16];
  logic               busy_q;
  logic               done_q;

  logic signed [13:0] ref_arr [16];
  logic signed [48:0] mu_prod;
  logic signed [48:0] mu_shift;
  logic signed [31:0] mu_e_d;
  logic signed [45:0] delta;
  logic signed [48:0] sum;
  logic signed [31:0] w_d;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ref_arr[i]               = ref_bus_i[14*i +: 14];
      weight_bus_o[32*i +: 32] = w_q[i];
    end
  end

  // Step size: full-precision product, arithmetic shift (floor), then saturate.
  always_comb begin
    mu_prod  = e_q * $signed({1'b0, MU_W});
    mu_shift = mu_prod >>> MU_SHIFT;
    if (mu_shift > MAX32)      mu_e_d = 32'sh7FFF_FFFF;
    else if (mu_shift < MIN32) mu_e_d = 32'sh8000_0000;
    else                       mu_e_d = mu_shift[31:0];
  end

  always_comb begin
    delta = mu_e_q * ref_arr[k_q];
    sum   = 49'(w_q[k_q]) + 49'(delta);
    if (sum > MAX32)      w_d = 32'sh7FFF_FFFF;
    else if (sum < MIN32) w_d = 32'sh8000_0000;
    else                  w_d = sum[31:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q     <= '0;
      e_q     <= '0;
      mu_e_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i && update_req_i) begin
            e_q     <= e_i;
            state_q <= LATCH;
            busy_q  <= 1'b1;
          end else if (clr_weights_i) begin
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
          end
        end
        LATCH: begin
          if (!enable_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            mu_e_q  <= mu_e_d;
            k_q     <= '0;
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          // An abort drops this edge's write; earlier taps keep their new values.
          if (!enable_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            w_q[k_q] <= w_d;
            k_q      <= k_q + 4'd1;
            if (k_q == 4'd15) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign update_done_o = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lms_weight_update.sv
// Bench for lms_weight_update: directed corner cases plus random steps, checked
// against an integer model of the LMS update tracked tap by tap.
module tb_lms_weight_update;

  localparam int unsigned MU       = 1;
  localparam int unsigned MU_SHIFT = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         enable = 1'b0;
  logic         update_req = 1'b0;
  logic         clr_weights = 1'b0;
  logic [31:0]  e_in = '0;
  logic [223:0] ref_bus = '0;
  logic [511:0] weight_bus;
  logic         busy;
  logic         update_done;
  logic [1:0]   dbg_state;

  lms_weight_update #(.MU(MU), .MU_SHIFT(MU_SHIFT)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable_i     (enable),
    .update_req_i (update_req),
    .e_i          (e_in),
    .ref_bus_i    (ref_bus),
    .clr_weights_i(clr_weights),
    .weight_bus_o (weight_bus),
    .busy_o       (busy),
    .update_done_o(update_done),
    .dbg_state_o  (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  longint       mw [16];
  logic [511:0] exp_q [$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [511:0] model_bus();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = mw[k][31:0];
    return b;
  endfunction

  function automatic longint ref_tap(input logic [223:0] rb, input int k);
    logic signed [13:0] t;
    t = rb[14*k +: 14];
    return longint'(t);
  endfunction

  function automatic logic [223:0] ref_const(input int v);
    logic [223:0] rb;
    for (int k = 0; k < 16; k++) rb[14*k +: 14] = 14'(v);
    return rb;
  endfunction

  function automatic logic [223:0] ref_rand();
    logic [223:0] rb;
    for (int k = 0; k < 16; k++) rb[14*k +: 14] = 14'($urandom_range(0, 16383));
    return rb;
  endfunction

  function automatic longint step_of(input logic [31:0] e);
    return sat32((longint'($signed(e)) * longint'(MU)) >>> MU_SHIFT);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_idle();
    clr_weights = 1'b1;
    tick();
    clr_weights = 1'b0;
    for (int k = 0; k < 16; k++) mw[k] = 0;
    chk("clr_idle", weight_bus, model_bus());
    chk("clr_idle_busy", 512'(busy), 512'(1'b0));
  endtask

  // One full request; abort_at >= 1 drops enable so it is sampled low at that edge.
  task automatic run_update(input logic [31:0] e, input logic [223:0] rb,
                            input int abort_at, input bit extra, input bit with_clr);
    longint mu_e;
    longint fin [16];
    bit     aborted;
    mu_e = step_of(e);
    for (int k = 0; k < 16; k++) fin[k] = sat32(mw[k] + mu_e * ref_tap(rb, k));
    if (abort_at < 0) begin
      logic [511:0] f;
      for (int k = 0; k < 16; k++) f[32*k +: 32] = fin[k][31:0];
      exp_q.push_back(f);
    end
    aborted     = 1'b0;
    ref_bus     = rb;
    e_in        = e;
    enable      = 1'b1;
    update_req  = 1'b1;
    clr_weights = with_clr;
    tick();
    update_req  = 1'b0;
    clr_weights = 1'b0;
    e_in        = $urandom;
    chk("busy_rise", 512'(busy), 512'(1'b1));
    chk("w_accept", weight_bus, model_bus());
    for (int ed = 1; ed <= 18; ed++) begin
      if (ed == abort_at) enable = 1'b0;
      if (extra && ed == 8) begin update_req = 1'b1; clr_weights = 1'b1; end
      if (extra && ed == 9) begin update_req = 1'b0; clr_weights = 1'b0; end
      tick();
      if (ed == abort_at) aborted = 1'b1;
      if (!aborted && ed >= 2 && ed <= 17) mw[ed-2] = fin[ed-2];
      chk($sformatf("w_edge%0d", ed), weight_bus, model_bus());
      chk($sformatf("done_edge%0d", ed), 512'(update_done), 512'(!aborted && ed == 17));
      chk($sformatf("busy_edge%0d", ed), 512'(busy), 512'(!aborted && ed <= 17));
      if (!aborted && ed == 17) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_final: got done with no expected entry");
        end else begin
          chk("sb_final", weight_bus, exp_q.pop_front());
        end
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    logic [31:0] e_r;
    for (int k = 0; k < 16; k++) mw[k] = 0;

    // reset values while held in reset
    #1;
    chk("rst_bus", weight_bus, 512'(0));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_done", 512'(update_done), 512'(1'b0));
    chk("rst_state", 512'(dbg_state), 512'(0));
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // asynchronous reset in the middle of an update
    ref_bus    = ref_const(5);
    e_in       = 32'd16;
    enable     = 1'b1;
    update_req = 1'b1;
    tick();
    update_req = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 7; k++) mw[k] = 5;
    chk("mid_update_w", weight_bus, model_bus());
    #2 rstn = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) mw[k] = 0;
    chk("async_rst_bus", weight_bus, model_bus());
    chk("async_rst_busy", 512'(busy), 512'(1'b0));
    chk("async_rst_done", 512'(update_done), 512'(1'b0));
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_done", 512'(update_done), 512'(1'b0));
      chk("post_rst_busy", 512'(busy), 512'(1'b0));
    end

    // basic step: mu_e = 1, ref_k = k+1
    begin
      logic [223:0] rb;
      for (int k = 0; k < 16; k++) rb[14*k +: 14] = 14'(k + 1);
      run_update(32'd16, rb, -1, 1'b0, 1'b0);
      chk("basic_w0", 512'(weight_bus[31:0]), 512'(32'd1));
      chk("basic_w15", 512'(weight_bus[511:480]), 512'(32'd16));
    end

    // negative step and accumulation
    clear_idle();
    run_update(-32'sd32, ref_const(100), -1, 1'b0, 1'b0);
    chk("neg_w7", 512'(weight_bus[255:224]), 512'(32'hFFFF_FF38));
    run_update(-32'sd32, ref_const(100), -1, 1'b0, 1'b0);
    chk("acc_w0", 512'(weight_bus[31:0]), 512'(32'hFFFF_FE70));

    // truncation toward minus infinity: -17/16 -> -2
    clear_idle();
    run_update(-32'sd17, ref_const(1), -1, 1'b0, 1'b0);
    chk("trunc_w3", 512'(weight_bus[127:96]), 512'(32'hFFFF_FFFE));

    // saturation both ways
    clear_idle();
    run_update(32'h7FFF_FFF0, ref_const(8191), -1, 1'b0, 1'b0);
    chk("sat_pos", 512'(weight_bus[63:32]), 512'(32'h7FFF_FFFF));
    run_update(32'h7FFF_FFF0, ref_const(-8192), -1, 1'b0, 1'b0);
    run_update(32'h7FFF_FFF0, ref_const(-8192), -1, 1'b0, 1'b0);
    chk("sat_neg", 512'(weight_bus[511:480]), 512'(32'h8000_0000));

    // abort: enable sampled low at edge 6
    clear_idle();
    run_update(32'd16, ref_const(1), 6, 1'b0, 1'b0);
    chk("abort_w3", 512'(weight_bus[127:96]), 512'(32'd1));
    chk("abort_w4", 512'(weight_bus[159:128]), 512'(32'd0));

    // request/clear pulses while busy are ignored
    run_update(32'd48, ref_rand(), -1, 1'b1, 1'b0);
    // request and clear together in IDLE: request wins
    run_update(32'd32, ref_rand(), -1, 1'b0, 1'b1);

    // random steps
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 0) e_r = 32'($urandom_range(0, 4000)) - 32'd2000;
      else                           e_r = $urandom;
      if ($urandom_range(0, 4) == 0) clear_idle();
      run_update(e_r, ref_rand(), -1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
